// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: serialises IFU fetches and LSU loads/stores onto one bus, one
// transaction in flight, LSU first. Define ARB_STARVE_GUARD_EN to bound IFU starvation.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_req_ready_o,
  input  logic                if_flush_i,
  output logic                if_rsp_valid_o,
  output logic [DATA_W-1:0]   if_rsp_data_o,
  output logic                if_rsp_err_o,
  input  logic                lsu_req_valid_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_req_ready_o,
  output logic                lsu_rsp_valid_o,
  output logic [DATA_W-1:0]   lsu_rsp_data_o,
  output logic                lsu_rsp_err_o,
  output logic                bus_req_valid_o,
  input  logic                bus_req_ready_i,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_rsp_valid_i,
  input  logic [DATA_W-1:0]   bus_rsp_data_i,
  input  logic                bus_rsp_err_i,
  output logic                ram_stall_if_o,
  output logic                ram_stall_mem_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LSU} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                drop_q, drop_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic idle, grant_lsu, grant_if, force_if;
  logic if_owned, lsu_owned, drop_now, rsp_fire, if_rsp_vld, lsu_rsp_vld;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_if = (starve_q == CNT_MAX) && if_req_valid_i;

  // Counts LSU wins that left the IFU waiting; any IFU grant starts a fresh window.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_lsu && if_req_valid_i && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants are gated by rst so a requester never sees an accept that reset discards.
  assign idle      = (state_q == IDLE) && !rst;
  assign grant_lsu = idle && lsu_req_valid_i && !force_if;
  assign grant_if  = idle && if_req_valid_i && !grant_lsu;

  assign if_owned  = (state_q != IDLE) && (owner_q == OWN_IF);
  assign lsu_owned = (state_q != IDLE) && (owner_q == OWN_LSU);
  assign drop_now  = drop_q || (if_owned && if_flush_i);
  assign rsp_fire  = (state_q == RSP) && bus_rsp_valid_i;

  assign if_rsp_vld  = rsp_fire && (owner_q == OWN_IF) && !drop_now;
  assign lsu_rsp_vld = rsp_fire && (owner_q == OWN_LSU);

  assign if_req_ready_o  = grant_if;
  assign lsu_req_ready_o = grant_lsu;

  assign if_rsp_valid_o  = if_rsp_vld;
  assign if_rsp_data_o   = if_rsp_vld ? bus_rsp_data_i : '0;
  assign if_rsp_err_o    = if_rsp_vld && bus_rsp_err_i;
  assign lsu_rsp_valid_o = lsu_rsp_vld;
  assign lsu_rsp_data_o  = lsu_rsp_vld ? bus_rsp_data_i : '0;
  assign lsu_rsp_err_o   = lsu_rsp_vld && bus_rsp_err_i;

  assign bus_req_valid_o = (state_q == REQ);
  assign bus_we_o        = we_q;
  assign bus_addr_o      = addr_q;
  assign bus_wdata_o     = wdata_q;
  assign bus_wstrb_o     = wstrb_q;

  // A flushed fetch no longer holds the IF stage, even while its bus beat drains.
  assign ram_stall_mem_o = ((idle && lsu_req_valid_i) || lsu_owned) && !lsu_rsp_vld;
  assign ram_stall_if_o  = ((idle && if_req_valid_i) || (if_owned && !drop_now)) && !if_rsp_vld;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_lsu) begin
          we_d    = lsu_we_i;
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          wstrb_d = lsu_wstrb_i;
          owner_d = OWN_LSU;
          state_d = REQ;
        end else if (grant_if) begin
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          wdata_d = '0;
          wstrb_d = '0;
          owner_d = OWN_IF;
          state_d = REQ;
        end
      end
      REQ: begin
        drop_d = drop_now;
        if (bus_req_ready_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        drop_d = drop_now;
        if (bus_rsp_valid_i) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected grants, bus requests and responses are
// queued with the stimulus and retired by a bus model and an output monitor.
module tb_mem_bus_arbiter;

  logic        clk, rst;
  logic        if_req_valid_i, if_req_ready_o, if_flush_i, if_rsp_valid_o, if_rsp_err_o;
  logic [31:0] if_addr_i;
  logic [63:0] if_rsp_data_o;
  logic        lsu_req_valid_i, lsu_we_i, lsu_req_ready_o, lsu_rsp_valid_o, lsu_rsp_err_o;
  logic [31:0] lsu_addr_i;
  logic [63:0] lsu_wdata_i, lsu_rsp_data_o;
  logic [7:0]  lsu_wstrb_i;
  logic        bus_req_valid_o, bus_req_ready_i, bus_we_o, bus_rsp_valid_i, bus_rsp_err_i;
  logic [31:0] bus_addr_o;
  logic [63:0] bus_wdata_o, bus_rsp_data_i;
  logic [7:0]  bus_wstrb_o;
  logic        ram_stall_if_o, ram_stall_mem_o;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid_i(if_req_valid_i), .if_addr_i(if_addr_i), .if_req_ready_o(if_req_ready_o),
    .if_flush_i(if_flush_i), .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
    .if_rsp_err_o(if_rsp_err_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_data_o(lsu_rsp_data_o),
    .lsu_rsp_err_o(lsu_rsp_err_o),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_rsp_valid_i(bus_rsp_valid_i), .bus_rsp_data_i(bus_rsp_data_i),
    .bus_rsp_err_i(bus_rsp_err_i),
    .ram_stall_if_o(ram_stall_if_o), .ram_stall_mem_o(ram_stall_mem_o)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } breq_t;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } rsp_t;

  localparam logic [1:0] G_LSU = 2'b10;
  localparam logic [1:0] G_IF  = 2'b01;

  breq_t      bus_exp_q[$];
  rsp_t       if_rsp_q[$];
  rsp_t       lsu_rsp_q[$];
  logic [1:0] grant_q[$];

  int   n_chk, n_pass;
  int   req_wait, rsp_wait;
  logic hs_flag;

  // Bus model state
  int    bm_hold, bm_rcnt;
  logic  bm_pend, bm_pwe;
  logic [31:0] bm_paddr;
  breq_t bm_held, bm_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] data_fn(input logic we, input logic [31:0] a);
    if (we) return 64'h0;
    if (a == 32'h8000_0000) return 64'h1234;
    return {a, ~a};
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return (a[11:0] == 12'hBAD);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic exp_if(input logic [31:0] a, input bit no_rsp);
    breq_t b;
    rsp_t  r;
    b.we = 1'b0; b.addr = a; b.wdata = 64'h0; b.wstrb = 8'h0;
    r.data = data_fn(1'b0, a); r.err = err_fn(a);
    grant_q.push_back(G_IF);
    bus_exp_q.push_back(b);
    if (!no_rsp) if_rsp_q.push_back(r);
  endtask

  task automatic exp_lsu(input logic we, input logic [31:0] a, input logic [63:0] wd,
                         input logic [7:0] ws);
    breq_t b;
    rsp_t  r;
    b.we = we; b.addr = a; b.wdata = wd; b.wstrb = ws;
    r.data = data_fn(we, a); r.err = err_fn(a);
    grant_q.push_back(G_LSU);
    bus_exp_q.push_back(b);
    lsu_rsp_q.push_back(r);
  endtask

  task automatic lsu_issue(input logic we, input logic [31:0] a, input logic [63:0] wd,
                           input logic [7:0] ws);
    bit done = 1'b0;
    @(negedge clk);
    lsu_req_valid_i = 1'b1; lsu_we_i = we; lsu_addr_i = a; lsu_wdata_i = wd; lsu_wstrb_i = ws;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (lsu_req_ready_o) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) chk("lsu_grant_timeout", 64'(lsu_req_ready_o), 64'd1);
    @(posedge clk); #1;
    lsu_req_valid_i = 1'b0;
  endtask

  task automatic if_issue(input logic [31:0] a);
    bit done = 1'b0;
    @(negedge clk);
    if_req_valid_i = 1'b1; if_addr_i = a;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (if_req_ready_o) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) chk("if_grant_timeout", 64'(if_req_ready_o), 64'd1);
    @(posedge clk); #1;
    if_req_valid_i = 1'b0;
  endtask

  task automatic wait_hs();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #3;
      seen = hs_flag;
    end
    if (!seen) chk("bus_hs_timeout", 64'(hs_flag), 64'd1);
  endtask

  task automatic wait_rsp();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #3;
      seen = bus_rsp_valid_i;
    end
    if (!seen) chk("bus_rsp_timeout", 64'(bus_rsp_valid_i), 64'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_rdy"},   64'(if_req_ready_o),  64'd0);
    chk({tag, "_lsu_rdy"},  64'(lsu_req_ready_o), 64'd0);
    chk({tag, "_bus_vld"},  64'(bus_req_valid_o), 64'd0);
    chk({tag, "_if_rsp"},   64'(if_rsp_valid_o),  64'd0);
    chk({tag, "_lsu_rsp"},  64'(lsu_rsp_valid_o), 64'd0);
    chk({tag, "_stall_if"}, 64'(ram_stall_if_o),  64'd0);
    chk({tag, "_stall_mem"},64'(ram_stall_mem_o), 64'd0);
  endtask

  // Downstream bus model: optional request backpressure, then a response after rsp_wait.
  initial begin
    bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_data_i = 64'h0; bus_rsp_err_i = 1'b0;
    hs_flag = 1'b0; bm_hold = 0; bm_rcnt = 0; bm_pend = 1'b0; bm_pwe = 1'b0; bm_paddr = 32'h0;
    bm_held = '0; bm_exp = '0;
    forever begin
      @(negedge clk);
      bus_rsp_valid_i = 1'b0; bus_rsp_data_i = 64'h0; bus_rsp_err_i = 1'b0;
      bus_req_ready_i = 1'b0; hs_flag = 1'b0;
      if (bm_pend) begin
        if (bm_rcnt >= rsp_wait) begin
          bus_rsp_valid_i = 1'b1;
          bus_rsp_data_i  = data_fn(bm_pwe, bm_paddr);
          bus_rsp_err_i   = err_fn(bm_paddr);
          bm_pend = 1'b0; bm_rcnt = 0;
        end else bm_rcnt++;
      end
      if (bus_req_valid_o && !bm_pend) begin
        if (bm_hold == 0) begin
          bm_held = {bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o};
        end else begin
          chk("bus_addr_stable",  64'(bus_addr_o), 64'(bm_held.addr));
          chk("bus_wdata_stable", bus_wdata_o, bm_held.wdata);
        end
        if (bm_hold >= req_wait) begin
          bus_req_ready_i = 1'b1; hs_flag = 1'b1;
          bm_hold = 0; bm_pend = 1'b1; bm_pwe = bus_we_o; bm_paddr = bus_addr_o;
          if (bus_exp_q.size() == 0) begin
            chk("bus_req_unexp", 64'(bus_req_valid_o), 64'd0);
          end else begin
            bm_exp = bus_exp_q.pop_front();
            chk("bus_we",    64'(bus_we_o),    64'(bm_exp.we));
            chk("bus_addr",  64'(bus_addr_o),  64'(bm_exp.addr));
            chk("bus_wstrb", 64'(bus_wstrb_o), 64'(bm_exp.wstrb));
            if (bm_exp.we) chk("bus_wdata", bus_wdata_o, bm_exp.wdata);
          end
        end else bm_hold++;
      end
    end
  end

  // Output monitor: retires grants and responses against the expectation queues.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk); #2;
      if (lsu_req_ready_o || if_req_ready_o) begin
        if (grant_q.size() == 0) chk("grant_unexp", 64'({lsu_req_ready_o, if_req_ready_o}), 64'd0);
        else chk("grant_order", 64'({lsu_req_ready_o, if_req_ready_o}), 64'(grant_q.pop_front()));
      end
      if (if_rsp_valid_o) begin
        if (if_rsp_q.size() == 0) chk("if_rsp_unexp", 64'(if_rsp_valid_o), 64'd0);
        else begin
          r = if_rsp_q.pop_front();
          chk("if_rsp_data", if_rsp_data_o, r.data);
          chk("if_rsp_err", 64'(if_rsp_err_o), 64'(r.err));
        end
      end
      if (lsu_rsp_valid_o) begin
        if (lsu_rsp_q.size() == 0) chk("lsu_rsp_unexp", 64'(lsu_rsp_valid_o), 64'd0);
        else begin
          r = lsu_rsp_q.pop_front();
          chk("lsu_rsp_data", lsu_rsp_data_o, r.data);
          chk("lsu_rsp_err", 64'(lsu_rsp_err_o), 64'(r.err));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    n_chk = 0; n_pass = 0; req_wait = 0; rsp_wait = 0;
    rst = 1'b1; if_req_valid_i = 1'b0; if_addr_i = 32'h0; if_flush_i = 1'b0;
    lsu_req_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 64'h0;
    lsu_wstrb_i = 8'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #2;
    chk_quiet("reset");

    // Single IFU read with a zero-wait bus: grant, request, response in consecutive cycles.
    exp_if(32'h8000_0000, 1'b0);
    @(negedge clk);
    if_req_valid_i = 1'b1; if_addr_i = 32'h8000_0000; #2;
    chk("t1_if_rdy_c0",   64'(if_req_ready_o),  64'd1);
    chk("t1_stall_if_c0", 64'(ram_stall_if_o),  64'd1);
    chk("t1_bus_vld_c0",  64'(bus_req_valid_o), 64'd0);
    @(posedge clk); #1; if_req_valid_i = 1'b0;
    @(negedge clk); #2;
    chk("t1_bus_vld_c1",  64'(bus_req_valid_o), 64'd1);
    chk("t1_stall_if_c1", 64'(ram_stall_if_o),  64'd1);
    chk("t1_if_rdy_c1",   64'(if_req_ready_o),  64'd0);
    @(negedge clk); #2;
    chk("t1_if_rsp_c2",   64'(if_rsp_valid_o),  64'd1);
    chk("t1_stall_if_c2", 64'(ram_stall_if_o),  64'd0);
    chk("t1_bus_vld_c2",  64'(bus_req_valid_o), 64'd0);
    @(negedge clk); #2;
    chk("t1_if_rsp_c3",   64'(if_rsp_valid_o),  64'd0);

    // Simultaneous requests: LSU write goes first, IFU follows.
    exp_lsu(1'b1, 32'h0000_2000, 64'h1111_2222_3333_4444, 8'h0F);
    exp_if(32'h8000_0100, 1'b0);
    fork
      lsu_issue(1'b1, 32'h0000_2000, 64'h1111_2222_3333_4444, 8'h0F);
      if_issue(32'h8000_0100);
    join
    wait_rsp();

    // Bus backpressure for 5 cycles: request held stable, MEM stall until the response.
    req_wait = 5;
    exp_lsu(1'b1, 32'h0000_1000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
    lsu_issue(1'b1, 32'h0000_1000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); #2;
      if (lsu_rsp_valid_o) begin
        chk("bp_stall_mem_rsp", 64'(ram_stall_mem_o), 64'd0);
        done = 1'b1;
      end else begin
        chk("bp_stall_mem_wait", 64'(ram_stall_mem_o), 64'd1);
      end
    end
    if (!done) chk("bp_rsp_timeout", 64'(lsu_rsp_valid_o), 64'd1);
    req_wait = 0;

    // Flush during RSP: the fetch completes on the bus but is never returned.
    rsp_wait = 2;
    exp_if(32'h8000_0400, 1'b1);
    if_issue(32'h8000_0400);
    wait_hs();
    @(negedge clk); if_flush_i = 1'b1; #2;
    chk("flush_stall_if_now", 64'(ram_stall_if_o), 64'd0);
    @(negedge clk); if_flush_i = 1'b0; #2;
    chk("flush_stall_if_held", 64'(ram_stall_if_o), 64'd0);
    wait_rsp();
    chk("flush_if_rsp", 64'(if_rsp_valid_o), 64'd0);

    // Flush in the same cycle as the bus response drops it too.
    rsp_wait = 1;
    exp_if(32'h8000_0500, 1'b1);
    if_issue(32'h8000_0500);
    wait_hs();
    @(negedge clk);
    @(negedge clk); if_flush_i = 1'b1; #2;
    chk("flush_same_if_rsp", 64'(if_rsp_valid_o), 64'd0);
    chk("flush_same_stall_if", 64'(ram_stall_if_o), 64'd0);
    @(negedge clk); if_flush_i = 1'b0; #2;
    chk("flush_same_bus_vld", 64'(bus_req_valid_o), 64'd0);

    // The next fetch after a flush is served normally.
    rsp_wait = 0;
    exp_if(32'h8000_0300, 1'b0);
    if_issue(32'h8000_0300);
    wait_rsp();

    // Reset while in RSP: back to IDLE at once, the late bus response is ignored.
    rsp_wait = 3;
    exp_if(32'h8000_0600, 1'b1);
    if_issue(32'h8000_0600);
    wait_hs();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #2;
    chk_quiet("rst_rsp");
    wait_rsp();
    chk("rst_late_rsp_ignored", 64'(if_rsp_valid_o), 64'd0);
    rsp_wait = 0;

    // Both requesters valid continuously; includes an LSU read that returns a bus error.
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      if (i == 4) exp_if(32'h8000_0200, 1'b0);
`endif
      exp_lsu(1'b0, (i == 2) ? 32'h2000_0BAD : 32'h2000_0000 + 32'(i * 8), 64'h0, 8'h0);
    end
`ifndef ARB_STARVE_GUARD_EN
    exp_if(32'h8000_0200, 1'b0);
`endif
    fork
      begin
        for (int i = 0; i < 6; i++)
          lsu_issue(1'b0, (i == 2) ? 32'h2000_0BAD : 32'h2000_0000 + 32'(i * 8), 64'h0, 8'h0);
      end
      if_issue(32'h8000_0200);
    join
    wait_rsp();

    repeat (5) @(negedge clk);
    #2;
    chk("grant_q_drained",   64'(grant_q.size()),   64'd0);
    chk("bus_q_drained",     64'(bus_exp_q.size()), 64'd0);
    chk("if_rsp_q_drained",  64'(if_rsp_q.size()),  64'd0);
    chk("lsu_rsp_q_drained", 64'(lsu_rsp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
